jk_ff_bank: RTL and testbench
=============================

// Module: jk_ff_bank
// PURPOSE
//  Parametrised bank of WIDTH JK-style flip-flops; successor to the single-bit JK flip-flop.
//  Runtime-selectable per-bank mode: JK, D, T or SR.
//  Also provides a saturating counter of bit changes and a sticky error flag for illegal SR input.
//  Used as a general state/flag register in control paths; driven through a SystemVerilog interface in the testbench.
// PARAMETERS
//  WIDTH      8      number of flip-flops (1..32)
//  CNT_W      8      width of change counter chg_cnt
//  RESET_VAL  '0     value loaded into q on reset, WIDTH bits
// PORTS
//  clk      in   1        rising-edge clock
//  rst      in   1        asynchronous, active-low reset
//  en       in   1        update enable; 0 -> q holds
//  clr      in   1        synchronous clear: q<=RESET_VAL, chg_cnt<=0, err<=0
//  mode     in   2        00 JK, 01 D (j is D), 10 T (j is T), 11 SR (j=S, k=R)
//  j        in   WIDTH    per-bit J / D / T / S input
//  k        in   WIDTH    per-bit K / R input; ignored in D and T modes
//  q        out  WIDTH    register state
//  qb       out  WIDTH    ~q, combinational from q
//  chg_cnt  out  CNT_W    saturating count of bit transitions on q
//  err      out  1        sticky flag: illegal SR input seen (S=R=1 on an enabled edge)
// BEHAVIOUR
//  Reset (rst=0, asynchronous, no clock needed):
//   - q=RESET_VAL, qb=~RESET_VAL, chg_cnt=0, err=0.
//   - Reset deassertion takes effect at the next rising edge; no update occurs on the edge at which rst rises.
//  Priority per rising edge: rst > clr > en. clr acts regardless of en.
//  Latency: q reflects inputs sampled at edge N immediately after edge N (1 cycle).
//  Next state per bit i when en=1 and clr=0:
//   - JK: 00 hold, 01 reset(0), 10 set(1), 11 toggle.
//   - D:  q[i]<=j[i].
//   - T:  j[i]=1 toggles, 0 holds.
//   - SR: 10 set, 01 reset, 00 hold, 11 hold and raise err.
//  mode is sampled each edge; a mode change applies on the same edge it is presented.
//  Change counter:
//   - d = popcount(q_next ^ q); chg_cnt <= min(chg_cnt + d, 2^CNT_W-1).
//   - Saturates at all-ones; never wraps.
//   - Changes caused by clr are not counted (clr zeroes the counter).
//   - d=0 when en=0.
//  err:
//   - Set on any enabled SR-mode edge with j[i]&k[i]=1 for some i.
//   - Held until clr or rst.
//   - If clr and an illegal SR input coincide, clr wins: err=0.
//  Reset mid-operation: all state returns to reset values immediately; pending inputs are discarded.
//  X/Z on j/k/mode when en=0: no effect on state.
// TESTING (WIDTH=8, CNT_W=8, RESET_VAL=8'h00)
//  1. Reset: assert rst=0 mid-cycle with q=8'hA5 -> q=8'h00, qb=8'hFF, chg_cnt=0, err=0 before next edge.
//  2. JK mode: en=1, j=8'hF0, k=8'h0F from q=00 -> q=F0, cnt=4.
//     Next edge j=k=8'hFF -> q=0F, cnt=12.
//  3. D/T modes: D mode with j=8'h3C -> q=3C.
//     Switch to T mode with j=8'h81 on the next edge -> q=BD; cnt adds 4 then 2.
//  4. SR illegal: mode=11, j=8'h01, k=8'h01 -> q unchanged, err=1.
//     err stays 1 over 3 legal edges; clr=1 -> err=0, q=00, cnt=0.
//  5. Saturation: T mode with j=8'hFF for 40 edges -> cnt stops at 255.
//     Then clr and (clr+illegal SR) on the same edge -> cnt=0, err=0.
//  6. en=0 with random j/k/mode for 10 edges -> q and chg_cnt unchanged.

Source files
------------

// File: rtl/jk_ff_bank.sv
// jk_ff_bank
//   A bank of WIDTH flip-flops. All bits share one mode, which is chosen at run time:
//   JK, D, T or SR. The block also counts bit transitions on q in a saturating counter.
//   It raises a sticky error flag when it sees an illegal SR input (S=R=1).
//
// Ports
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous active-low reset
//   en       in   1        update enable; 0 holds q and chg_cnt
//   clr      in   1        synchronous clear of q, chg_cnt and err; acts regardless of en
//   mode     in   2        00 JK, 01 D, 10 T, 11 SR
//   j        in   WIDTH    J / D / T / S per bit
//   k        in   WIDTH    K / R per bit; ignored in D and T modes
//   q        out  WIDTH    register state
//   qb       out  WIDTH    ~q
//   chg_cnt  out  CNT_W    saturating count of bit transitions on q
//   err      out  1        sticky illegal-SR flag
module jk_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             err
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // The popcount can reach WIDTH. The sum of the count and the popcount
  // never exceeds (2^CNT_W - 1) + WIDTH, so CNT_W + POP_W bits always hold it.
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] diff;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_sat;
  logic             sr_illegal;

  // Next-state function. When en=0 the block holds, so the values on j, k
  // and mode cannot reach any state.
  always_comb begin
    q_nxt      = q_q;
    sr_illegal = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: q_nxt = (j & ~q_q) | (~k & q_q);
        MODE_D:  q_nxt = j;
        MODE_T:  q_nxt = q_q ^ j;
        MODE_SR: begin
          // S=R=1 holds the bit. Only the set-only and reset-only cases change it.
          q_nxt      = (q_q | (j & ~k)) & ~(k & ~j);
          sr_illegal = |(j & k);
        end
        default: q_nxt = q_q;
      endcase
    end
  end

  always_comb begin
    diff = q_nxt ^ q_q;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
    sum = SUM_W'(cnt_q) + SUM_W'(pop);
    if (sum > SUM_W'(CNT_MAX)) begin
      cnt_sat = CNT_MAX;
    end else begin
      cnt_sat = sum[CNT_W-1:0];
    end
  end

  // clr wins over any update on the same edge. That includes an illegal SR
  // input, so err is cleared rather than set.
  always_comb begin
    q_d   = q_nxt;
    cnt_d = cnt_sat;
    err_d = err_q | sr_illegal;
    if (clr) begin
      q_d   = RESET_VAL;
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign q       = q_q;
  assign qb      = ~q_q;
  assign chg_cnt = cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
module tb_jk_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] q;
  logic [7:0] qb;
  logic [7:0] chg_cnt;
  logic       err;

  jk_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .j(j), .k(k), .q(q), .qb(qb), .chg_cnt(chg_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] q;
    logic [7:0] cnt;
    logic       err;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [7:0] m_q;
  logic [7:0] m_cnt;
  logic       m_err;

  task automatic check(input exp_t e);
    n_vec++;
    if (q !== e.q || qb !== ~e.q || chg_cnt !== e.cnt || err !== e.err) begin
      n_miss++;
      $display("FAIL %s: got q=%h qb=%h cnt=%0d err=%b, want q=%h qb=%h cnt=%0d err=%b",
               e.name, q, qb, chg_cnt, err, e.q, ~e.q, e.cnt, e.err);
    end
  endtask

  // Called just after a negedge. The caller drives the inputs and queues the
  // expected result. The result is checked 1 ns after the next rising edge,
  // and the task returns at the following negedge.
  task automatic apply(input string name, input logic a_en, input logic a_clr,
                       input logic [1:0] a_mode, input logic [7:0] a_j, input logic [7:0] a_k,
                       input logic [7:0] e_q, input logic [7:0] e_cnt, input logic e_err);
    exp_t e;
    en = a_en; clr = a_clr; mode = a_mode; j = a_j; k = a_k;
    e.name = name; e.q = e_q; e.cnt = e_cnt; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, got q=%h want an entry", name, q);
    end else begin
      check(sb.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00; j = '0; k = '0;

    // Reset state, then a mid-cycle asynchronous reset from q=A5.
    @(negedge clk);
    e.name = "reset_state"; e.q = 8'h00; e.cnt = 8'd0; e.err = 1'b0;
    check(e);
    rst = 1'b1;
    apply("load_a5", 1, 0, 2'b01, 8'hA5, 8'h00, 8'hA5, 8'd4, 0);
    #2 rst = 1'b0;
    #1;
    e.name = "async_reset"; e.q = 8'h00; e.cnt = 8'd0; e.err = 1'b0;
    check(e);
    @(negedge clk);
    rst = 1'b1;

    // Table: en, clr, mode, j, k -> q, cnt, err
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8'hF0, 8'h0F, 8'hF0, 8'd4,  1'b0}); // JK set/reset
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF, 8'h0F, 8'd12, 1'b0}); // JK toggle
    tbl.push_back('{1'b1, 1'b0, 2'b01, 8'h3C, 8'h00, 8'h3C, 8'd16, 1'b0}); // D
    tbl.push_back('{1'b1, 1'b0, 2'b10, 8'h81, 8'h00, 8'hBD, 8'd18, 1'b0}); // T
    tbl.push_back('{1'b1, 1'b0, 2'b11, 8'h01, 8'h01, 8'hBD, 8'd18, 1'b1}); // SR illegal
    tbl.push_back('{1'b1, 1'b0, 2'b11, 8'h40, 8'h00, 8'hFD, 8'd19, 1'b1}); // SR set, err sticky
    tbl.push_back('{1'b1, 1'b0, 2'b11, 8'h00, 8'h80, 8'h7D, 8'd20, 1'b1}); // SR reset
    tbl.push_back('{1'b1, 1'b0, 2'b11, 8'h00, 8'h00, 8'h7D, 8'd20, 1'b1}); // SR hold
    tbl.push_back('{1'b1, 1'b1, 2'b11, 8'h02, 8'h00, 8'h00, 8'd0,  1'b0}); // clr
    tbl.push_back('{1'b0, 1'b0, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'd0,  1'b0}); // en=0 hold
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8'h0A, 8'h00, 8'h0A, 8'd2,  1'b0}); // JK set only
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8'h01, 8'h08, 8'h03, 8'd4,  1'b0}); // JK mixed
    tbl.push_back('{1'b0, 1'b0, 2'b11, 8'hFF, 8'h00, 8'h03, 8'd4,  1'b0}); // en=0 SR
    tbl.push_back('{1'b1, 1'b0, 2'b01, 8'h03, 8'hFF, 8'h03, 8'd4,  1'b0}); // D ignores k
    tbl.push_back('{1'b1, 1'b0, 2'b10, 8'h01, 8'hFF, 8'h02, 8'd5,  1'b0}); // T ignores k

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].en, tbl[i].clr, tbl[i].mode,
            tbl[i].j, tbl[i].k, tbl[i].q, tbl[i].cnt, tbl[i].err);
    end

    // Saturation: every edge toggles all 8 bits.
    m_q = 8'h02; m_cnt = 8'd5; m_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      m_q = ~m_q;
      m_cnt = (int'(m_cnt) + 8 > 255) ? 8'd255 : m_cnt + 8'd8;
      apply($sformatf("sat%0d", n), 1, 0, 2'b10, 8'hFF, 8'h00, m_q, m_cnt, m_err);
    end

    apply("clr_en0",        0, 1, 2'b10, 8'hFF, 8'h00, 8'h00, 8'd0, 0);
    apply("sr_illegal_2",   1, 0, 2'b11, 8'h01, 8'h01, 8'h00, 8'd0, 1);
    apply("clr_vs_illegal", 1, 1, 2'b11, 8'h01, 8'h01, 8'h00, 8'd0, 0);

    // en=0 with random inputs, while err is set.
    apply("load_5a",        1, 0, 2'b01, 8'h5A, 8'h00, 8'h5A, 8'd4, 0);
    apply("sr_illegal_3",   1, 0, 2'b11, 8'h81, 8'h81, 8'h5A, 8'd4, 1);
    for (int n = 0; n < 10; n++) begin
      apply($sformatf("en0_rand%0d", n), 0, 0, 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 8'h5A, 8'd4, 1);
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
